fcc_seq_ctrl: RTL and testbench
===============================

// Module: fcc_seq_ctrl
// PURPOSE
//   Sequencer for the finger-counting converter (9-bit codeword -> 4-bit count, 0 = invalid).
//   Accepts codewords over a valid/ready stream and drives the converter input from a register.
//   Samples the converter result after a settle delay and returns it on a valid/ready output stream.
//   Keeps error/sum statistics and locks the input after too many consecutive invalid codewords.
// PARAMETERS
//   SETTLE_CYCLES  1   cycles between driving conv_cw and sampling conv_result (legal range 1..15)
//   ERR_LIMIT      3   consecutive invalid results that trigger LOCK (legal range 1..15)
// PORTS
//   clk          in   1   clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   in_valid     in   1   codeword available
//   in_ready     out  1   block accepts codeword this cycle
//   in_cw        in   9   codeword
//   conv_cw      out  9   registered codeword driven to converter
//   conv_result  in   4   converter output (1..10 valid, 0 invalid; 11..15 treated as invalid)
//   out_valid    out  1   result available
//   out_ready    in   1   downstream accepts result
//   out_value    out  4   sampled converter result
//   out_err      out  1   qualifies out_value: 1 = invalid codeword
//   lock         out  1   high while in LOCK
//   clear_lock   in   1   single-cycle pulse: leave LOCK
//   clear_stats  in   1   synchronous clear of err_cnt and sum_cnt
//   err_cnt      out  8   invalid codewords seen, saturates at 255
//   sum_cnt      out  12  sum of valid out_value, saturates at 4095
// BEHAVIOUR
//   Reset: state=IDLE; in_ready=0 during reset, 1 the first cycle after;
//     conv_cw, out_value, err_cnt, sum_cnt, and the consecutive-error counter = 0;
//     out_valid=0, out_err=0, lock=0.
//   FSM states: IDLE, SETTLE, EMIT, LOCK. in_ready = (state==IDLE). No overlap of transactions.
//   IDLE: on in_valid & in_ready, latch conv_cw <= in_cw, load timer = SETTLE_CYCLES, -> SETTLE.
//   SETTLE: timer decrements each cycle. In the cycle timer==1, register:
//     out_value <= conv_result; out_err <= (conv_result==0 || conv_result>10); -> EMIT.
//   EMIT: out_valid=1; out_value and out_err are held stable until out_valid & out_ready.
//     On the handshake:
//       invalid result: err_cnt += 1 (saturating); consecutive-error counter += 1.
//       valid result: sum_cnt += out_value (saturating); consecutive-error counter cleared.
//     Next state: -> LOCK if the consecutive-error counter reaches ERR_LIMIT on this handshake,
//       otherwise -> IDLE.
//   Latency: accept edge to out_valid high = SETTLE_CYCLES+1 cycles.
//     Minimum period = SETTLE_CYCLES+2 cycles per codeword.
//   LOCK: lock=1, in_ready=0, out_valid=0. On clear_lock: clear the consecutive-error counter, -> IDLE.
//     clear_lock outside LOCK is ignored.
//   conv_cw holds its last value except when a new codeword is accepted.
//   clear_stats: zeroes err_cnt and sum_cnt next edge in any state.
//     When it coincides with an EMIT handshake, clear wins (counts stay 0 for that handshake).
//     It does not affect the FSM or the consecutive-error counter.
//   in_valid while in_ready=0: ignored, no data loss at this block (upstream must hold).
//   rst_n asserted mid-transaction: everything returns to reset values immediately;
//     the pending result is dropped.
// TESTING
//   T1: cw=9'h047, converter model ->1, SETTLE_CYCLES=1
//       -> out_valid 2 cycles after accept, out_value=1, out_err=0, sum_cnt=1.
//   T2: stream 9'h047(1), 9'h17E(5), 9'h008(10), out_ready tied high
//       -> values 1,5,10 in order, sum_cnt=16, one accept per 3 cycles.
//   T3: out_ready low for 5 cycles in EMIT
//       -> out_valid/out_value stable, in_ready=0 throughout, no second accept.
//   T4: 9'h0CD, 9'h153, 9'h1D5 (all ->0) -> out_err=1 each, err_cnt=3, lock=1, in_ready=0.
//       Then clear_lock -> IDLE; a valid word is then accepted.
//   T5: 9'h0CD(0), 9'h047(1), 9'h0CD(0) -> no lock (consecutive-error counter reset), err_cnt=2.
//   T6: rst_n low during SETTLE -> out_valid=0, counters 0;
//       clear_stats coinciding with a handshake -> err_cnt=0 and sum_cnt=0 afterwards.

Source files
------------

// File: rtl/fcc_seq_ctrl.sv
// Sequencer for the finger-counting converter: accepts a codeword, lets the converter settle,
// returns the sampled count on an output stream and keeps error/sum statistics with an error lock.
module fcc_seq_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned ERR_LIMIT     = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [8:0]  in_cw,
  output logic [8:0]  conv_cw,
  input  logic [3:0]  conv_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_value,
  output logic        out_err,
  output logic        lock,
  input  logic        clear_lock,
  input  logic        clear_stats,
  output logic [7:0]  err_cnt,
  output logic [11:0] sum_cnt
);

  localparam int unsigned TMR_W  = 4;
  localparam int unsigned RUN_W  = 4;
  localparam int unsigned RUN_XW = RUN_W + 1;
  localparam int unsigned SUM_W  = 12;
  localparam int unsigned SUM_XW = SUM_W + 1;

  typedef enum logic [1:0] {IDLE, SETTLE, EMIT, LOCK} state_t;

  state_t              state;
  logic [TMR_W-1:0]    timer;
  logic [RUN_W-1:0]    err_run;

  logic                res_err_c;
  logic [RUN_XW-1:0]   run_inc_c;
  logic                run_hit_c;
  logic [SUM_XW-1:0]   sum_ext_c;
  logic [SUM_W-1:0]    sum_sat_c;

  // Result classification and saturating statistic arithmetic
  assign res_err_c = (conv_result == 4'd0) || (conv_result > 4'd10);
  assign run_inc_c = {1'b0, err_run} + RUN_XW'(1);
  assign run_hit_c = run_inc_c >= RUN_XW'(ERR_LIMIT);
  assign sum_ext_c = {1'b0, sum_cnt} + SUM_XW'(out_value);
  assign sum_sat_c = sum_ext_c[SUM_W] ? '1 : sum_ext_c[SUM_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      conv_cw   <= '0;
      timer     <= '0;
      out_value <= '0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
      lock      <= 1'b0;
      err_cnt   <= '0;
      sum_cnt   <= '0;
      err_run   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            conv_cw  <= in_cw;
            timer    <= TMR_W'(SETTLE_CYCLES);
            in_ready <= 1'b0;
            state    <= SETTLE;
          end else begin
            in_ready <= 1'b1;
          end
        end
        SETTLE: begin
          timer <= timer - TMR_W'(1);
          if (timer <= TMR_W'(1)) begin
            out_value <= conv_result;
            out_err   <= res_err_c;
            out_valid <= 1'b1;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_err) begin
              if (err_cnt != '1) err_cnt <= err_cnt + 8'd1;
              err_run <= RUN_W'(run_inc_c);
              if (run_hit_c) begin
                lock  <= 1'b1;
                state <= LOCK;
              end else begin
                in_ready <= 1'b1;
                state    <= IDLE;
              end
            end else begin
              sum_cnt  <= sum_sat_c;
              err_run  <= '0;
              in_ready <= 1'b1;
              state    <= IDLE;
            end
          end
        end
        LOCK: begin
          if (clear_lock) begin
            err_run  <= '0;
            lock     <= 1'b0;
            in_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // Placed last so a coincident handshake update is overridden
      if (clear_stats) begin
        err_cnt <= '0;
        sum_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fcc_seq_ctrl.sv
// Bench for fcc_seq_ctrl: a random codeword->count table stands in for the converter, and a
// transaction-level model (expected-result queue plus running statistics) predicts every output.
module tb_fcc_seq_ctrl;

  localparam int unsigned S   = 1;
  localparam int unsigned LIM = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [8:0]  in_cw, conv_cw;
  logic [3:0]  conv_result;
  logic        out_valid, out_ready;
  logic [3:0]  out_value;
  logic        out_err, lock, clear_lock, clear_stats;
  logic [7:0]  err_cnt;
  logic [11:0] sum_cnt;

  logic [3:0]  lut [512];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          m_err, m_sum, m_cons;
  bit          m_lock;
  int          exp_q[$];
  logic [8:0]  wq[$];

  fcc_seq_ctrl #(.SETTLE_CYCLES(S), .ERR_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_cw(in_cw),
    .conv_cw(conv_cw), .conv_result(conv_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_value(out_value), .out_err(out_err), .lock(lock), .clear_lock(clear_lock),
    .clear_stats(clear_stats), .err_cnt(err_cnt), .sum_cnt(sum_cnt)
  );

  always #5 clk = ~clk;
  assign conv_result = lut[conv_cw];

  function automatic bit is_bad(int v);
    return (v == 0) || (v > 10);
  endfunction

  task automatic model_reset();
    m_err = 0; m_sum = 0; m_cons = 0; m_lock = 0;
    exp_q.delete();
  endtask

  task automatic pulse_clear_stats();
    @(negedge clk); clear_stats = 1'b1;
    @(negedge clk); clear_stats = 1'b0;
    m_err = 0; m_sum = 0;
  endtask

  // Streams wq through the DUT; everything observed is compared against the model at each negedge.
  task automatic drive_stream(int ready_pct, int stats_pct, bit stats_on_hs, bit auto_clear,
                              bit check_period, int max_cycles);
    int idx = 0, cyc = 0, acc_cyc = -100, last_acc = -100, v;
    bit prev_ov = 1'b0, done = 1'b0, hs;
    while (!done) begin
      @(negedge clk); cyc++;
      n_cmp++;
      if (err_cnt !== 8'(m_err) || sum_cnt !== 12'(m_sum) || lock !== m_lock) begin
        n_fail++;
        $display("FAIL stats cyc=%0d: err_cnt=%0d sum_cnt=%0d lock=%0b, required %0d %0d %0b",
                 cyc, err_cnt, sum_cnt, lock, m_err, m_sum, m_lock);
      end
      if (out_valid && !prev_ov) begin
        n_cmp++;
        if (cyc - acc_cyc != int'(S) + 1) begin
          n_fail++;
          $display("FAIL latency: out_valid after %0d cycles, required %0d", cyc - acc_cyc, S + 1);
        end
      end
      if (out_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_out: out_valid=1 with no pending codeword, required 0");
        end else if (out_value !== 4'(exp_q[0]) || out_err !== is_bad(exp_q[0]) || in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL out_data: value=%0d err=%0b in_ready=%0b, required %0d %0b 0",
                   out_value, out_err, in_ready, exp_q[0], is_bad(exp_q[0]));
        end
      end
      prev_ov = out_valid;
      if (cyc > max_cycles) begin
        n_cmp++; n_fail++;
        $display("FAIL timeout: %0d of %0d words accepted, %0d pending", idx, wq.size(), exp_q.size());
        done = 1'b1;
      end else if (exp_q.size() == 0 && !out_valid &&
                   (idx == wq.size() || (m_lock && !auto_clear))) begin
        done = 1'b1;
      end
      if (done) begin
        in_valid = 1'b0; out_ready = 1'b0; clear_stats = 1'b0; clear_lock = 1'b0;
      end else begin
        out_ready   = ($urandom_range(99) < ready_pct);
        hs          = out_valid && out_ready;
        clear_stats = stats_on_hs ? hs : ($urandom_range(99) < stats_pct);
        clear_lock  = auto_clear && ($urandom_range(3) == 0);
        if (m_lock && clear_lock) begin m_lock = 0; m_cons = 0; end
        in_valid = 1'b0;
        if (idx < wq.size() && (check_period || $urandom_range(3) != 0)) begin
          in_valid = 1'b1;
          in_cw    = wq[idx];
          if (in_ready) begin
            exp_q.push_back(int'(lut[wq[idx]]));
            if (check_period && last_acc >= 0) begin
              n_cmp++;
              if (cyc - last_acc != int'(S) + 2) begin
                n_fail++;
                $display("FAIL period: accept spacing %0d cycles, required %0d", cyc - last_acc, S + 2);
              end
            end
            last_acc = cyc; acc_cyc = cyc; idx++;
          end
        end else begin
          in_cw = 9'($urandom);
        end
        if (hs) begin
          v = exp_q.pop_front();
          if (is_bad(v)) begin
            m_err = (m_err < 255) ? m_err + 1 : 255;
            m_cons++;
            if (m_cons == int'(LIM)) m_lock = 1;
          end else begin
            m_sum = (m_sum + v > 4095) ? 4095 : m_sum + v;
            m_cons = 0;
          end
        end
        if (clear_stats) begin m_err = 0; m_sum = 0; end
      end
    end
    wq.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_cw = '0; out_ready = 1'b0;
    clear_lock = 1'b0; clear_stats = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_err !== 1'b0 || lock !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: in_ready=%0b out_valid=%0b out_err=%0b lock=%0b, required all 0",
               in_ready, out_valid, out_err, lock);
    end
    n_cmp++;
    if (conv_cw !== 9'd0 || out_value !== 4'd0 || err_cnt !== 8'd0 || sum_cnt !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_data: conv_cw=%0h out_value=%0d err_cnt=%0d sum_cnt=%0d, required all 0",
               conv_cw, out_value, err_cnt, sum_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: in_ready=%0b one cycle after reset, required 1", in_ready);
    end
  endtask

  task automatic test_single();
    wq = '{9'h047};
    drive_stream(100, 0, 1'b0, 1'b0, 1'b1, 50);
    n_cmp++;
    if (sum_cnt !== 12'd1 || conv_cw !== 9'h047) begin
      n_fail++;
      $display("FAIL single: sum_cnt=%0d conv_cw=%0h, required 1 047", sum_cnt, conv_cw);
    end
  endtask

  task automatic test_back_to_back();
    pulse_clear_stats();
    wq = '{9'h047, 9'h17E, 9'h008};
    drive_stream(100, 0, 1'b0, 1'b0, 1'b1, 50);
    n_cmp++;
    if (sum_cnt !== 12'd16) begin
      n_fail++;
      $display("FAIL b2b_sum: sum_cnt=%0d, required 16", sum_cnt);
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_cw = 9'h047; out_ready = 1'b0;
    @(negedge clk);
    in_cw = 9'h17E;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    repeat (5) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_value !== 4'd1 || out_err !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold: out_valid=%0b value=%0d err=%0b in_ready=%0b, required 1 1 0 0",
                 out_valid, out_value, out_err, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    m_sum += 1; m_cons = 0;
    n_cmp++;
    if (out_valid !== 1'b0 || conv_cw !== 9'h047 || sum_cnt !== 12'(m_sum)) begin
      n_fail++;
      $display("FAIL release: out_valid=%0b conv_cw=%0h sum_cnt=%0d, required 0 047 %0d",
               out_valid, conv_cw, sum_cnt, m_sum);
    end
  endtask

  task automatic test_lock();
    wq = '{9'h0CD, 9'h153, 9'h1D5};
    drive_stream(100, 0, 1'b0, 1'b0, 1'b0, 60);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (lock !== 1'b1 || in_ready !== 1'b0 || err_cnt !== 8'd3 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lock: lock=%0b in_ready=%0b err_cnt=%0d out_valid=%0b, required 1 0 3 0",
               lock, in_ready, err_cnt, out_valid);
    end
    clear_lock = 1'b1;
    @(negedge clk);
    clear_lock = 1'b0;
    m_lock = 0; m_cons = 0;
    n_cmp++;
    if (lock !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL unlock: lock=%0b in_ready=%0b, required 0 1", lock, in_ready);
    end
    wq = '{9'h17E};
    drive_stream(100, 0, 1'b0, 1'b0, 1'b0, 50);
  endtask

  task automatic test_err_run_reset();
    pulse_clear_stats();
    wq = '{9'h0CD, 9'h047, 9'h0CD};
    drive_stream(100, 0, 1'b0, 1'b0, 1'b0, 60);
    n_cmp++;
    if (lock !== 1'b0 || err_cnt !== 8'd2 || sum_cnt !== 12'd1) begin
      n_fail++;
      $display("FAIL err_run: lock=%0b err_cnt=%0d sum_cnt=%0d, required 0 2 1", lock, err_cnt, sum_cnt);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    in_valid = 1'b1; in_cw = 9'h008;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || err_cnt !== 8'd0 || sum_cnt !== 12'd0 ||
        conv_cw !== 9'd0) begin
      n_fail++;
      $display("FAIL mid_reset: out_valid=%0b in_ready=%0b err_cnt=%0d sum_cnt=%0d conv_cw=%0h, required all 0",
               out_valid, in_ready, err_cnt, sum_cnt, conv_cw);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (4) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL dropped: out_valid=%0b after reset, required 0", out_valid);
      end
    end
  endtask

  task automatic test_clear_on_handshake();
    wq = '{9'h17E, 9'h0CD, 9'h008};
    drive_stream(100, 0, 1'b1, 1'b0, 1'b0, 60);
    n_cmp++;
    if (err_cnt !== 8'd0 || sum_cnt !== 12'd0) begin
      n_fail++;
      $display("FAIL clear_hs: err_cnt=%0d sum_cnt=%0d, required 0 0", err_cnt, sum_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) wq.push_back(9'($urandom));
    drive_stream(60, 3, 1'b0, 1'b1, 1'b0, 4000);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) lut[i] = 4'($urandom_range(15));
    lut[9'h047] = 4'd1;  lut[9'h17E] = 4'd5;  lut[9'h008] = 4'd10;
    lut[9'h0CD] = 4'd0;  lut[9'h153] = 4'd0;  lut[9'h1D5] = 4'd0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_lock();
    test_err_run_reset();
    test_mid_reset();
    test_clear_on_handshake();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
